// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file with three combinational read
// ports, one write port, optional same-cycle write bypass and a busy-bit
// scoreboard that flags read-after-write hazards back to decode.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              hazard,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_R0 != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic              w_wr_en;
    logic              w_set_en;
    logic              w_inc;
    logic              w_dec;
    logic [DEPTH-1:0]  w_busy_nxt;

    // Read value of one port: hard zero, then forwarded write data, then storage.
    // Forwarding is blocked while rst is held so all read ports show 0 in reset.
    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
        if (ZR && a == '0)
            return '0;
        else if (BP && !rst && we && wa == a)
            return wd;
        else
            return r_mem[a];
    endfunction

    // A busy source only hazards if this cycle's write cannot forward it.
    function automatic logic src_hazard(input logic [ADDR_W-1:0] a);
        return r_busy[a] && !(BP && we && wa == a);
    endfunction

    // Write and scoreboard-set qualifiers; register 0 is inert when hardwired.
    always_comb begin
        w_wr_en  = we && !(ZR && wa == '0);
        w_set_en = iss_v && !(ZR && iss_rd == '0);
    end

    // Next busy vector: clear on write, then set on issue so a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (we)
            w_busy_nxt[wa] = 1'b0;
        if (w_set_en)
            w_busy_nxt[iss_rd] = 1'b1;
    end

    // Effective 0->1 and 1->0 transitions that move the busy counter.
    always_comb begin
        w_inc = w_set_en && !r_busy[iss_rd];
        w_dec = we && r_busy[wa] && !(w_set_en && iss_rd == wa);
    end

    // Combinational read ports and hazard.
    always_comb begin
        rd1    = rd_port(rs1);
        rd2    = rd_port(rs2);
        rd3    = rd_port(rd);
        hazard = src_hazard(rs1) || src_hazard(rs2);
    end

    assign busy_cnt = r_busy_cnt;

    // Register storage: async clear, one write per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[wa] <= wd;
        end
    end

    // Busy vector and its population counter, kept in lockstep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case ({w_inc, w_dec})
                2'b10:   r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(1);
                2'b01:   r_busy_cnt <= r_busy_cnt - (ADDR_W+1)'(1);
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb. Two instances share stimulus,
// one with bypass and one without. Expected values are queued by the driver
// and checked by a separate monitor process when a sample is signalled.
module tb_regfile_sb;

    localparam int DW = 16;
    localparam int AW = 4;

    // Output selectors for the scoreboard.
    localparam int S_RD1 = 0, S_RD2 = 1, S_RD3 = 2, S_HAZ = 3, S_CNT = 4,
                   S_NRD1 = 5, S_NHAZ = 6, S_NCNT = 7;

    typedef struct {
        int    sel;
        int    exp;
        string name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0, wa = '0, iss_rd = '0;
    logic [DW-1:0] wd = '0;
    logic          we = 1'b0, iss_v = 1'b0;

    logic [DW-1:0] rd1, rd2, rd3, n_rd1, n_rd2, n_rd3;
    logic          hazard, n_hazard;
    logic [AW:0]   busy_cnt, n_busy_cnt;

    exp_t q[$];
    event smp;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd1(rd1), .rd2(rd2), .rd3(rd3), .we(we), .wa(wa), .wd(wd),
        .iss_v(iss_v), .iss_rd(iss_rd), .hazard(hazard), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd1(n_rd1), .rd2(n_rd2), .rd3(n_rd3), .we(we), .wa(wa), .wd(wd),
        .iss_v(iss_v), .iss_rd(iss_rd), .hazard(n_hazard), .busy_cnt(n_busy_cnt)
    );

    function automatic int get_out(input int sel);
        case (sel)
            S_RD1:   return int'(rd1);
            S_RD2:   return int'(rd2);
            S_RD3:   return int'(rd3);
            S_HAZ:   return int'(hazard);
            S_CNT:   return int'(busy_cnt);
            S_NRD1:  return int'(n_rd1);
            S_NHAZ:  return int'(n_hazard);
            S_NCNT:  return int'(n_busy_cnt);
            default: return -1;
        endcase
    endfunction

    // Monitor: on each sample request, drain and compare queued expectations.
    initial begin
        forever begin
            @(smp);
            while (q.size() > 0) begin
                exp_t e;
                int   act;
                e   = q.pop_front();
                act = get_out(e.sel);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 'h%0h expected 'h%0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input int sel, input int exp, input string name);
        exp_t e;
        e.sel = sel; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    // Ask the monitor to sample now; a queue left undrained is a failure.
    task automatic sample();
        #1;
        -> smp;
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic idle();
        we = 1'b0; iss_v = 1'b0;
    endtask

    // Inputs change just after the falling edge, well away from the rising edge.
    task automatic next_cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        // Reset held from time 0.
        @(negedge clk);
        expect_v(S_RD1, 0, "rst_rd1");
        expect_v(S_CNT, 0, "rst_cnt");
        expect_v(S_HAZ, 0, "rst_haz");
        sample();
        rst = 1'b0;

        // Load reg5 and claim it, then assert reset between edges.
        next_cyc();
        we = 1'b1; wa = 4'd5; wd = 16'h1234; iss_v = 1'b1; iss_rd = 4'd5;
        next_cyc();
        rs1 = 4'd5;
        expect_v(S_RD1, 'h1234, "load_rd1");
        expect_v(S_NRD1, 'h1234, "load_nb_rd1");
        expect_v(S_CNT, 1, "load_cnt");
        expect_v(S_HAZ, 1, "load_haz");
        sample();
        rst = 1'b1;
        expect_v(S_RD1, 0, "async_rst_rd1");
        expect_v(S_NRD1, 0, "async_rst_nb_rd1");
        expect_v(S_CNT, 0, "async_rst_cnt");
        expect_v(S_HAZ, 0, "async_rst_haz");
        sample();
        rst = 1'b0;

        // Write with bypass vs without.
        next_cyc();
        we = 1'b1; wa = 4'd3; wd = 16'hDADA; rs1 = 4'd3;
        expect_v(S_RD1, 'hDADA, "bypass_rd1");
        expect_v(S_NRD1, 0, "nobypass_old_rd1");
        sample();
        next_cyc();
        rd = 4'd3;
        expect_v(S_RD1, 'hDADA, "post_edge_rd1");
        expect_v(S_NRD1, 'hDADA, "nb_post_edge_rd1");
        expect_v(S_RD3, 'hDADA, "post_edge_rd3");
        sample();

        // Register 0 ignores writes and issues.
        next_cyc();
        we = 1'b1; wa = 4'd0; wd = 16'hFFFF; iss_v = 1'b1; iss_rd = 4'd0; rs1 = 4'd0;
        expect_v(S_RD1, 0, "r0_bypass_rd1");
        expect_v(S_HAZ, 0, "r0_haz");
        sample();
        next_cyc();
        expect_v(S_RD1, 0, "r0_rd1");
        expect_v(S_CNT, 0, "r0_cnt");
        expect_v(S_HAZ, 0, "r0_haz_after");
        sample();

        // Scoreboard: issue r7, write it three cycles later.
        iss_v = 1'b1; iss_rd = 4'd7;
        next_cyc();
        rs2 = 4'd7;
        expect_v(S_CNT, 1, "sb_cnt");
        expect_v(S_HAZ, 1, "sb_haz_n1");
        sample();
        next_cyc();
        expect_v(S_HAZ, 1, "sb_haz_n2");
        sample();
        next_cyc();
        we = 1'b1; wa = 4'd7; wd = 16'h00AA;
        expect_v(S_HAZ, 0, "sb_haz_resolved");
        expect_v(S_NHAZ, 1, "sb_nb_haz_write_cyc");
        expect_v(S_RD2, 'h00AA, "sb_rd2");
        expect_v(S_CNT, 1, "sb_cnt_write_cyc");
        sample();
        next_cyc();
        expect_v(S_CNT, 0, "sb_cnt_after");
        expect_v(S_HAZ, 0, "sb_haz_after");
        expect_v(S_NHAZ, 0, "sb_nb_haz_after");
        expect_v(S_RD2, 'h00AA, "sb_rd2_after");
        sample();

        // Simultaneous set and clear of the same register.
        rs2 = 4'd0;
        iss_v = 1'b1; iss_rd = 4'd4;
        next_cyc();
        rs1 = 4'd4;
        we = 1'b1; wa = 4'd4; wd = 16'h0044; iss_v = 1'b1; iss_rd = 4'd4;
        expect_v(S_CNT, 1, "sc_cnt_before");
        expect_v(S_HAZ, 0, "sc_haz_resolved");
        sample();
        next_cyc();
        expect_v(S_CNT, 1, "sc_cnt_same_reg");
        expect_v(S_HAZ, 1, "sc_still_busy");
        sample();
        // Move ownership from r4 to r6.
        we = 1'b1; wa = 4'd4; wd = 16'h0045; iss_v = 1'b1; iss_rd = 4'd6;
        next_cyc();
        expect_v(S_CNT, 1, "mv_cnt");
        expect_v(S_HAZ, 0, "mv_r4_free");
        sample();
        rs2 = 4'd6;
        expect_v(S_HAZ, 1, "mv_r6_busy");
        sample();
        we = 1'b1; wa = 4'd6; wd = 16'h0066;
        next_cyc();
        rs1 = 4'd0; rs2 = 4'd0;
        expect_v(S_CNT, 0, "mv_cnt_clear");
        sample();

        // Counter bounds: claim every register, including r0 and a duplicate.
        for (int i = 0; i < 16; i++) begin
            iss_v = 1'b1; iss_rd = AW'(i);
            next_cyc();
        end
        expect_v(S_CNT, 15, "full_cnt");
        expect_v(S_NCNT, 15, "full_nb_cnt");
        sample();
        iss_v = 1'b1; iss_rd = 4'd9;
        next_cyc();
        expect_v(S_CNT, 15, "reissue_cnt");
        sample();
        for (int i = 1; i < 16; i++) begin
            we = 1'b1; wa = AW'(i); wd = DW'(i * 16'h0101);
            next_cyc();
        end
        expect_v(S_CNT, 0, "drain_cnt");
        sample();
        we = 1'b1; wa = 4'd3; wd = 16'h0303;
        next_cyc();
        we = 1'b1; wa = 4'd5; wd = 16'h0505;
        next_cyc();
        rs1 = 4'd9;
        expect_v(S_CNT, 0, "no_underflow_cnt");
        expect_v(S_NCNT, 0, "no_underflow_nb_cnt");
        expect_v(S_RD1, 'h0909, "drain_rd1");
        sample();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks);
        $fatal(1, "timeout");
    end

endmodule
